restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 22 ++
 rtl/restoring_divider.sv | 141 ++++++++++++++
 tb/tb_restoring_divider.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider.
// The state enum and widths are common to the top level and the iteration slice.
package div_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int ITER_N     = 16;
    localparam int DIV_LAT    = 18;
    localparam int CNT_W      = $clog2(ITER_N);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor,
// and keep the difference only when it does not go negative.
module div_step
    import div_pkg::*;
(
    input  logic [DIVISOR_W-1:0] rem_in,
    input  logic                 next_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] partial;

    // The partial remainder needs one extra bit; after a successful subtract it fits back in 8.
    always_comb begin
        partial = {rem_in, next_bit};
        q_bit   = (partial >= {1'b0, divisor});
        rem_out = q_bit ? DIVISOR_W'(partial - {1'b0, divisor}) : partial[DIVISOR_W-1:0];
    end

endmodule

// File: rtl/restoring_divider.sv
// Signed 16-by-8 restoring divider with valid/ready handshakes and a fixed 18-cycle latency.
// Magnitudes are divided MSB first over 16 cycles, then signs are applied in a single fix-up cycle.
module restoring_divider
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] Z,
    input  logic [DIVISOR_W-1:0]  Y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] Q,
    output logic [DIVISOR_W-1:0]  R,
    output logic                  DZ,
    output logic                  OVF
);

    state_t                state;
    state_t                next_state;

    logic [DIVIDEND_W-1:0] z_reg;
    logic [DIVISOR_W-1:0]  y_reg;
    logic [DIVIDEND_W-1:0] shift;
    logic [DIVISOR_W-1:0]  y_mag;
    logic [DIVISOR_W-1:0]  rem;
    logic [CNT_W-1:0]      count;
    logic                  q_sign;
    logic                  r_sign;
    logic                  dz_flag;

    logic [DIVIDEND_W-1:0] z_abs;
    logic [DIVISOR_W-1:0]  y_abs;
    logic [DIVISOR_W-1:0]  rem_next;
    logic                  q_bit;
    logic                  ovf_now;
    logic [DIVIDEND_W-1:0] q_signed;
    logic [DIVISOR_W-1:0]  r_signed;

    div_step u_step (
        .rem_in  (rem),
        .next_bit(shift[DIVIDEND_W-1]),
        .divisor (y_mag),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = PREP;
            PREP:    next_state = ITER;
            ITER:    if (count == '0) next_state = FIX;
            FIX:     next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // An unsigned 16-bit magnitude already holds |-32768| = 32768, so no 17th bit is stored.
    always_comb begin
        z_abs    = z_reg[DIVIDEND_W-1] ? -z_reg : z_reg;
        y_abs    = y_reg[DIVISOR_W-1] ? -y_reg : y_reg;
        ovf_now  = ~dz_flag & ~q_sign & shift[DIVIDEND_W-1];
        q_signed = q_sign ? -shift : shift;
        r_signed = r_sign ? -rem : rem;
    end

    // The shift register starts as |Z| and fills with quotient bits from the right.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_reg   <= '0;
            y_reg   <= '0;
            shift   <= '0;
            y_mag   <= '0;
            rem     <= '0;
            count   <= '0;
            q_sign  <= 1'b0;
            r_sign  <= 1'b0;
            dz_flag <= 1'b0;
            Q       <= '0;
            R       <= '0;
            DZ      <= 1'b0;
            OVF     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        z_reg <= Z;
                        y_reg <= Y;
                    end
                end
                PREP: begin
                    shift   <= z_abs;
                    y_mag   <= y_abs;
                    rem     <= '0;
                    q_sign  <= z_reg[DIVIDEND_W-1] ^ y_reg[DIVISOR_W-1];
                    r_sign  <= z_reg[DIVIDEND_W-1];
                    dz_flag <= (y_reg == '0);
                    count   <= CNT_W'(ITER_N - 1);
                end
                ITER: begin
                    shift <= {shift[DIVIDEND_W-2:0], q_bit};
                    rem   <= rem_next;
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end
                end
                FIX: begin
                    DZ  <= dz_flag;
                    OVF <= ovf_now;
                    if (dz_flag) begin
                        Q <= '0;
                        R <= '0;
                    end else if (ovf_now) begin
                        Q <= 16'h8000;
                        R <= '0;
                    end else begin
                        Q <= q_signed;
                        R <= r_signed;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed corner cases plus randomized operands
// compared against an integer-arithmetic reference model.
module tb_restoring_divider;
    import div_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] Z;
    logic [7:0]  Y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Q;
    logic [7:0]  R;
    logic        DZ;
    logic        OVF;

    int n_checks;
    int n_pass;

    restoring_divider dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Z        (Z),
        .Y        (Y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Q        (Q),
        .R        (R),
        .DZ       (DZ),
        .OVF      (OVF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: SV integer division truncates toward zero and % takes the dividend's sign.
    function automatic void ref_div(input logic [15:0] z, input logic [7:0] y,
                                    output logic [15:0] q, output logic [7:0] r,
                                    output logic dz, output logic ovf);
        int zi;
        int yi;
        zi  = int'($signed(z));
        yi  = int'($signed(y));
        dz  = 1'b0;
        ovf = 1'b0;
        if (yi == 0) begin
            dz = 1'b1;
            q  = 16'h0000;
            r  = 8'h00;
        end else if (zi / yi > 32767) begin
            ovf = 1'b1;
            q   = 16'h8000;
            r   = 8'h00;
        end else begin
            q = 16'(zi / yi);
            r = 8'(zi % yi);
        end
    endfunction

    // Presents operands for one accept edge and waits (bounded) for out_valid.
    task automatic run_op(input logic [15:0] z, input logic [7:0] y, input bit noise,
                          output logic [15:0] q, output logic [7:0] r,
                          output logic dz, output logic ovf, output int lat);
        Z        = z;
        Y        = y;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                Z        = 16'($urandom);
                Y        = 8'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        q   = Q;
        r   = R;
        dz  = DZ;
        ovf = OVF;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        Z        = 16'd1000;
        Y        = 8'd7;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        else n_pass++;
        n_checks++;
        if ({Q, R, DZ, OVF} !== 26'd0)
            $display("[TB] FAIL reset_outputs: got Q=%h R=%h DZ=%b OVF=%b expected all zero", Q, R, DZ, OVF);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [15:0] zs [3] = '{16'd1000, -16'sd1000, 16'd1000};
        logic [7:0]  ys [3] = '{8'd7, 8'd7, -8'sd7};
        logic [15:0] eq [3] = '{16'h008E, 16'hFF72, 16'hFF72};
        logic [7:0]  er [3] = '{8'h06, 8'hFA, 8'h06};
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz, ovf;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run_op(zs[i], ys[i], 1'b0, q, r, dz, ovf, lat);
            n_checks++;
            if (lat != DIV_LAT) $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", i, lat, DIV_LAT);
            else n_pass++;
            n_checks++;
            if (q !== eq[i] || r !== er[i])
                $display("[TB] FAIL directed%0d_result: got Q=%h R=%h expected Q=%h R=%h", i, q, r, eq[i], er[i]);
            else n_pass++;
            n_checks++;
            if (dz !== 1'b0 || ovf !== 1'b0)
                $display("[TB] FAIL directed%0d_flags: got DZ=%b OVF=%b expected 0 0", i, dz, ovf);
            else n_pass++;
            finish_op();
        end
    endtask

    task automatic test_div_zero();
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz, ovf;
        int          lat;
        run_op(16'h1234, 8'h00, 1'b0, q, r, dz, ovf, lat);
        n_checks++;
        if (lat != DIV_LAT) $display("[TB] FAIL dz_latency: got %0d expected %0d", lat, DIV_LAT);
        else n_pass++;
        n_checks++;
        if (dz !== 1'b1 || ovf !== 1'b0 || q !== 16'h0000 || r !== 8'h00)
            $display("[TB] FAIL dz_result: got DZ=%b OVF=%b Q=%h R=%h expected 1 0 0000 00", dz, ovf, q, r);
        else n_pass++;
        finish_op();
    endtask

    task automatic test_overflow();
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz, ovf;
        int          lat;
        run_op(16'h8000, 8'hFF, 1'b0, q, r, dz, ovf, lat);
        n_checks++;
        if (lat != DIV_LAT) $display("[TB] FAIL ovf_latency: got %0d expected %0d", lat, DIV_LAT);
        else n_pass++;
        n_checks++;
        if (ovf !== 1'b1 || dz !== 1'b0 || q !== 16'h8000 || r !== 8'h00)
            $display("[TB] FAIL ovf_result: got OVF=%b DZ=%b Q=%h R=%h expected 1 0 8000 00", ovf, dz, q, r);
        else n_pass++;
        finish_op();
    endtask

    task automatic test_backpressure();
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz, ovf;
        int          lat;
        run_op(16'd300, 8'h80, 1'b0, q, r, dz, ovf, lat);
        n_checks++;
        if (q !== 16'hFFFE || r !== 8'h2C || lat != DIV_LAT)
            $display("[TB] FAIL bp_result: got Q=%h R=%h lat=%0d expected FFFE 2C %0d", q, r, lat, DIV_LAT);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            Z        = 16'($urandom);
            Y        = 8'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || Q !== 16'hFFFE || R !== 8'h2C)
                $display("[TB] FAIL bp_hold%0d: got ov=%b ir=%b Q=%h R=%h expected 1 0 FFFE 2C",
                         i, out_valid, in_ready, Q, R);
            else n_pass++;
        end
        in_valid = 1'b0;
        finish_op();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("[TB] FAIL bp_release: got ov=%b ir=%b expected 0 1", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid_iter();
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz, ovf;
        int          lat;
        int          spurious;
        Z        = 16'd1000;
        Y        = 8'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("[TB] FAIL midreset_state: got ir=%b ov=%b expected 1 0", in_ready, out_valid);
        else n_pass++;
        spurious = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) spurious++;
        end
        n_checks++;
        if (spurious != 0) $display("[TB] FAIL midreset_no_pulse: got %0d valid cycles expected 0", spurious);
        else n_pass++;
        run_op(16'd1000, 8'd7, 1'b0, q, r, dz, ovf, lat);
        n_checks++;
        if (q !== 16'h008E || r !== 8'h06 || dz !== 1'b0 || ovf !== 1'b0 || lat != DIV_LAT)
            $display("[TB] FAIL midreset_followup: got Q=%h R=%h DZ=%b OVF=%b lat=%0d expected 008E 06 0 0 %0d",
                     q, r, dz, ovf, lat, DIV_LAT);
        else n_pass++;
        finish_op();
    endtask

    task automatic test_back_to_back();
        logic [15:0] q, eq;
        logic [7:0]  r, er;
        logic        dz, ovf, edz, eovf;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] z;
            logic [7:0]  y;
            z = 16'($urandom);
            y = 8'($urandom_range(1, 255));
            ref_div(z, y, eq, er, edz, eovf);
            run_op(z, y, 1'b0, q, r, dz, ovf, lat);
            n_checks++;
            if (q !== eq || r !== er || dz !== edz || ovf !== eovf || lat != DIV_LAT)
                $display("[TB] FAIL b2b%0d: got Q=%h R=%h DZ=%b OVF=%b lat=%0d expected %h %h %b %b %0d",
                         i, q, r, dz, ovf, lat, eq, er, edz, eovf, DIV_LAT);
            else n_pass++;
            finish_op();
            n_checks++;
            if (in_ready !== 1'b1) $display("[TB] FAIL b2b%0d_ready: got %b expected 1", i, in_ready);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [15:0] z, q, eq;
        logic [7:0]  y, r, er;
        logic        dz, ovf, edz, eovf;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0:       z = 16'h8000;
                1:       z = 16'h7FFF;
                2:       z = 16'hFFFF;
                default: z = 16'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       y = 8'h00;
                1:       y = 8'hFF;
                2:       y = 8'h80;
                3:       y = 8'h01;
                4:       y = 8'h7F;
                default: y = 8'($urandom);
            endcase
            ref_div(z, y, eq, er, edz, eovf);
            run_op(z, y, 1'($urandom_range(0, 1)), q, r, dz, ovf, lat);
            n_checks++;
            if (lat != DIV_LAT) $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", i, lat, DIV_LAT);
            else n_pass++;
            n_checks++;
            if (q !== eq) $display("[TB] FAIL rand%0d_Q: Z=%h Y=%h got %h expected %h", i, z, y, q, eq);
            else n_pass++;
            n_checks++;
            if (r !== er) $display("[TB] FAIL rand%0d_R: Z=%h Y=%h got %h expected %h", i, z, y, r, er);
            else n_pass++;
            n_checks++;
            if (dz !== edz || ovf !== eovf)
                $display("[TB] FAIL rand%0d_flags: got DZ=%b OVF=%b expected %b %b", i, dz, ovf, edz, eovf);
            else n_pass++;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            finish_op();
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Z         = '0;
        Y         = '0;
        test_reset();
        test_directed();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_reset_mid_iter();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
